// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD adder.
// Holds the control FSM state type, BCD digit constants and the
// nine's-complement helper used when an operand set is captured.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Nine's complement of one digit; an illegal digit (>9) simply wraps
    // in 4 bits, and the adder keeps going with that value.
    function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_seq_adder_if.sv
// Handshake/data bundle of the sequential BCD adder.
//   in_valid/in_ready   : operand-set handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, err)
// master = producer/consumer side (bench), slave = the adder itself.
interface bcd_seq_adder_if #(
    parameter int DIGITS = 4
) ();
    localparam int W = DIGITS * 4;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, err
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, err
    );

endinterface

// File: rtl/bcd_digit_add.sv
// One BCD digit adder with decimal correction (purely combinational).
//   a, b : 4-bit digits (b already complemented for subtraction)
//   cin  : carry from the previous digit
//   s    : corrected 4-bit digit result
//   cout : decimal carry to the next digit
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);

    logic [DIGIT_W:0] w_t;

    // Binary add, then add 6 whenever the raw sum leaves the decimal range.
    always_comb begin
        w_t = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        if (w_t > {1'b0, BCD_MAX}) begin
            s    = w_t[DIGIT_W-1:0] + BCD_CORR;
            cout = 1'b1;
        end else begin
            s    = w_t[DIGIT_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_seq_adder.sv
// Sequential BCD adder/subtractor: one digit per clock, LSD first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of bcd_seq_adder_if (operand and result handshakes)
// Parameters: DIGITS (1..16) digits per operand; REG_OUT selects whether
// sum/cout/err come from dedicated output registers or the working registers.
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter bit REG_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_seq_adder_if.slave  bus
);

    localparam int W     = DIGITS * DIGIT_W;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e             r_state;
    state_e             w_state_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_err;
    logic [IDX_W-1:0]   r_idx;

    logic [W-1:0]       w_b_comp;
    logic               w_in_err;
    logic [W-1:0]       w_sum_next;
    logic [DIGIT_W-1:0] w_a_dig;
    logic [DIGIT_W-1:0] w_b_dig;
    logic [DIGIT_W-1:0] w_s_dig;
    logic               w_c_dig;
    logic               w_last;
    logic               w_in_ready;
    logic               w_out_valid;

    assign w_last = (r_idx == IDX_W'(DIGITS - 1));

    bcd_digit_add u_digit (
        .a    (w_a_dig),
        .b    (w_b_dig),
        .cin  (r_carry),
        .s    (w_s_dig),
        .cout (w_c_dig)
    );

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;

    // Capture-side preprocessing: B complemented for subtraction, and the
    // illegal-digit flag taken from the raw operands.
    always_comb begin
        w_b_comp = bus.b;
        w_in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            w_b_comp[i*DIGIT_W +: DIGIT_W] = nines_comp(bus.b[i*DIGIT_W +: DIGIT_W]);
            w_in_err = w_in_err
                     | (bus.a[i*DIGIT_W +: DIGIT_W] > BCD_MAX)
                     | (bus.b[i*DIGIT_W +: DIGIT_W] > BCD_MAX);
        end
    end

    // Select the operand digits addressed by the running index.
    always_comb begin
        w_a_dig = 4'd0;
        w_b_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_a_dig = (r_idx == IDX_W'(i)) ? r_a[i*DIGIT_W +: DIGIT_W] : w_a_dig;
            w_b_dig = (r_idx == IDX_W'(i)) ? r_b[i*DIGIT_W +: DIGIT_W] : w_b_dig;
        end
    end

    // Merge the freshly computed digit into the working sum.
    always_comb begin
        w_sum_next = r_sum;
        for (int i = 0; i < DIGITS; i++) begin
            w_sum_next[i*DIGIT_W +: DIGIT_W] = (r_idx == IDX_W'(i)) ? w_s_dig
                                             : r_sum[i*DIGIT_W +: DIGIT_W];
        end
    end

    // Working registers: capture in IDLE, one digit per cycle in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_sum   <= {W{1'b0}};
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= {IDX_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? w_b_comp : bus.b;
                        r_carry <= bus.sub ? 1'b1 : bus.cin;
                        r_err   <= w_in_err;
                        r_sum   <= {W{1'b0}};
                        r_idx   <= {IDX_W{1'b0}};
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_c_dig;
                    // The index parks on the last digit; it only wraps on the way back to IDLE.
                    if (!w_last) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_idx <= {IDX_W{1'b0}};
                    end
                end
                default: begin
                    r_idx <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic [W-1:0] r_o_sum;
            logic         r_o_cout;
            logic         r_o_err;

            // Result registers load together with the final digit, so they are
            // already stable on the first cycle out_valid is high.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_o_sum  <= {W{1'b0}};
                    r_o_cout <= 1'b0;
                    r_o_err  <= 1'b0;
                end else if ((r_state == RUN) && w_last) begin
                    r_o_sum  <= w_sum_next;
                    r_o_cout <= w_c_dig;
                    r_o_err  <= r_err;
                end
            end

            assign bus.sum  = r_o_sum;
            assign bus.cout = r_o_cout;
            assign bus.err  = r_o_err;
        end else begin : g_direct_out
            assign bus.sum  = r_sum;
            assign bus.cout = r_carry;
            assign bus.err  = r_err;
        end
    endgenerate

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Self-checking bench for bcd_seq_adder (DIGITS=4, REG_OUT=1).
// A decimal reference model (integer arithmetic for legal operands, the
// digit-wise add/correct rule when an operand holds an illegal digit) feeds
// an expectation queue; one compare process checks the handshake outputs
// every cycle and the result whenever out_valid is expected.
module tb_bcd_seq_adder;

    localparam int DIGITS = 4;
    localparam int W      = DIGITS * 4;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         e;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t exp_q[$];
    bit   ref_busy = 1'b0;
    int   ref_wait = 0;

    logic [W-1:0] last_sum;
    logic         last_cout;
    logic         last_err;

    bcd_seq_adder_if #(.DIGITS(DIGITS)) bus ();

    bcd_seq_adder #(.DIGITS(DIGITS), .REG_OUT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t r;
        int   modv, va, vb, t, carry, da, db;
        bit   legal;
        modv  = 1;
        legal = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            modv = modv * 10;
            if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) legal = 1'b0;
        end
        r.e = !legal;
        if (legal) begin
            va = bcd2int(a);
            vb = bcd2int(b);
            if (sub) begin
                r.c = (va >= vb);
                r.s = int2bcd(va >= vb ? va - vb : modv + va - vb);
            end else begin
                t   = va + vb + int'(cin);
                r.c = (t >= modv);
                r.s = int2bcd(t % modv);
            end
        end else begin
            carry = sub ? 1 : int'(cin);
            r.s   = '0;
            for (int i = 0; i < DIGITS; i++) begin
                da = int'(a[i*4 +: 4]);
                db = int'(b[i*4 +: 4]);
                if (sub) db = (9 - db) & 15;
                t = da + db + carry;
                if (t > 9) begin
                    r.s[i*4 +: 4] = 4'((t + 6) & 15);
                    carry = 1;
                end else begin
                    r.s[i*4 +: 4] = 4'(t);
                    carry = 0;
                end
            end
            r.c = (carry != 0);
        end
        return r;
    endfunction

    // Cycle-by-cycle comparison against the reference protocol and result queue.
    always @(negedge clk) begin
        bit   exp_ov;
        exp_t pm;
        if (!rst_n) begin
            chk("rst_in_ready", bus.in_ready, 1'b1);
            chk("rst_out_valid", bus.out_valid, 1'b0);
            chk("rst_sum", bus.sum, '0);
            chk("rst_cout", bus.cout, 1'b0);
            chk("rst_err", bus.err, 1'b0);
            ref_busy = 1'b0;
            exp_q.delete();
        end else begin
            if (ref_busy) ref_wait++;
            exp_ov = ref_busy && ((ref_wait - 1) >= DIGITS);
            chk("in_ready", bus.in_ready, !ref_busy);
            chk("out_valid", bus.out_valid, exp_ov);
            if (exp_ov && exp_q.size() > 0) begin
                chk("sum", bus.sum, exp_q[0].s);
                chk("cout", bus.cout, exp_q[0].c);
                chk("err", bus.err, exp_q[0].e);
            end
            if (!ref_busy && bus.in_valid) begin
                pm = model(bus.a, bus.b, bus.cin, bus.sub);
                exp_q.push_back(pm);
                ref_busy = 1'b1;
                ref_wait = 0;
            end else if (exp_ov && bus.out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                ref_busy = 1'b0;
            end
        end
    end

    // Entered and left at posedge+#2.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s, input int hold);
        int k;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(posedge clk); #2;
            k++;
        end
        chk("ready_wait", bus.in_ready, 1'b1);
        bus.a = a; bus.b = b; bus.cin = c; bus.sub = s;
        bus.in_valid = 1'b1;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            @(posedge clk); #2;
            k++;
        end
        chk("latency", k, DIGITS);
        last_sum  = bus.sum;
        last_cout = bus.cout;
        last_err  = bus.err;
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a = W'($urandom);
            @(posedge clk); #2;
            chk("hold_sum", bus.sum, last_sum);
            chk("hold_in_ready", bus.in_ready, 1'b0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #2;
        bus.out_ready = 1'b0;
        chk("idle_after_ack", bus.in_ready, 1'b1);
    endtask

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            if (allow_bad && $urandom_range(0, 7) == 0) r[i*4 +: 4] = 4'($urandom_range(10, 15));
            else r[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // Main stimulus sequence.
    initial begin
        exp_t pin;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
        bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        pin = model(16'h1234, 16'h5678, 1'b0, 1'b0);
        chk("pin_add", {pin.s, pin.c, pin.e}, {16'h6912, 1'b0, 1'b0});
        pin = model(16'h9999, 16'h0001, 1'b0, 1'b0);
        chk("pin_wrap", {pin.s, pin.c}, {16'h0000, 1'b1});
        pin = model(16'h5000, 16'h1234, 1'b0, 1'b1);
        chk("pin_sub_pos", {pin.s, pin.c}, {16'h3766, 1'b1});
        pin = model(16'h1234, 16'h5000, 1'b1, 1'b1);
        chk("pin_sub_neg", {pin.s, pin.c}, {16'h6234, 1'b0});
        pin = model(16'h00A0, 16'h0000, 1'b0, 1'b0);
        chk("pin_err", {pin.s, pin.c, pin.e}, {16'h0100, 1'b0, 1'b1});

        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 0);
        chk("d_add", {last_sum, last_cout, last_err}, {16'h6912, 1'b0, 1'b0});
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 1);
        chk("d_wrap", {last_sum, last_cout}, {16'h0000, 1'b1});
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0);
        chk("d_cin", {last_sum, last_cout}, {16'h0001, 1'b0});
        run_op(16'h5000, 16'h1234, 1'b0, 1'b1, 0);
        chk("d_sub_pos", {last_sum, last_cout}, {16'h3766, 1'b1});
        run_op(16'h1234, 16'h5000, 1'b1, 1'b1, 0);
        chk("d_sub_neg", {last_sum, last_cout}, {16'h6234, 1'b0});
        run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 0);
        chk("d_err", {last_sum, last_err}, {16'h0100, 1'b1});
        run_op(16'h4321, 16'h1111, 1'b0, 1'b0, 10);
        chk("d_hold", last_sum, 16'h5432);

        // Abort in the middle of RUN (digit index 2).
        bus.a = 16'h8888; bus.b = 16'h1111; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_sum", bus.sum, '0);
        chk("abort_in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_op(16'h2468, 16'h1357, 1'b1, 1'b0, 0);
        chk("d_after_abort", {last_sum, last_cout}, {16'h3826, 1'b0});

        for (int n = 0; n < 40; n++) begin
            run_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bcd_seq_adder.md
BCD_SEQ_ADDER -- requirements
Module: bcd_seq_adder

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits per operand (legal range 1..16).
REQ-002 Parameter REG_OUT, default 1, when 1 sum/cout/err are held in output registers; when 0 they are driven from the working registers and are valid only while out_valid=1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
REQ-008 b  input  4*DIGITS  operand B, packed BCD.
REQ-009 cin  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  0 = A+B+cin, 1 = A-B (ten's-complement).
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  4*DIGITS  packed BCD result.
REQ-014 cout  output  1  decimal carry-out; in subtract mode 1 = non-negative result.
REQ-015 err  output  1  at least one operand digit was >9.

Function
REQ-016 FSM states: IDLE, RUN, DONE; encoding from the shared package.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE: on in_valid=1 the block captures a, b, cin, sub, clears digit index to 0, and moves to RUN.
REQ-019 Capture: when sub=1 each B digit is replaced by its nine's complement (9-d) and the initial carry is 1; otherwise the initial carry is cin.
REQ-020 RUN: one digit per cycle, least significant first; at index i, t = A[i] + B'[i] + carry (5 bits).
REQ-021 Correction: when t>9, the digit result is (t+6)[3:0] and the next carry is 1; otherwise the digit result is t[3:0] and the next carry is 0.
REQ-022 RUN exits to DONE on the cycle that processes digit DIGITS-1; out_valid rises exactly DIGITS cycles after the accepting edge.
REQ-023 cout SHALL equal the carry out of digit DIGITS-1.
REQ-024 err SHALL be the OR over all captured A digits and all raw B digits of (digit>9), evaluated before complementing; processing continues unchanged.
REQ-025 DONE: sum, cout and err SHALL remain stable until out_valid&&out_ready; the block then returns to IDLE on that edge.
REQ-026 No new operand is accepted in RUN or DONE; in_valid during those states is ignored and nothing is queued.
REQ-027 The digit index wraps to 0 on entry to IDLE; no other wrap is permitted.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, in_ready 1, out_valid 0, sum 0, cout 0, err 0, index 0, working registers 0.
REQ-029 Reset asserted during RUN or DONE SHALL abort the operation with no result emitted; the first accept after release starts a fresh operation.
REQ-030 Release of rst_n SHALL take effect on the next rising edge of clk.

Structure
REQ-031 Shared package bcd_pkg SHALL hold the FSM state type, DIGIT_W=4, BCD_MAX=9 and BCD_CORR=6.
REQ-032 The per-digit add/correct logic SHALL be a combinational sub-module bcd_digit_add (4-bit a, 4-bit b, cin, 4-bit s, cout), instantiated once.

Verification (DIGITS=4)
REQ-033 a=0x1234, b=0x5678, sub=0, cin=0 -> sum=0x6912, cout=0, err=0, out_valid 4 cycles after accept.
REQ-034 a=0x9999, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1; a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
REQ-035 sub=1: a=0x5000, b=0x1234 -> sum=0x3766, cout=1; a=0x1234, b=0x5000 -> sum=0x6234, cout=0.
REQ-036 a=0x00A0, b=0x0000 -> err=1, result still emitted after 4 cycles.
REQ-037 Hold out_ready=0 for 10 cycles in DONE while toggling in_valid -> sum stable, in_ready=0, no second capture; then out_ready=1 -> IDLE next cycle.
REQ-038 Assert rst_n=0 at digit index 2 of RUN -> out_valid=0, sum=0, in_ready=1 immediately; next operand set completes normally.
